// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU command path: opcode values, command widths
// and the scheduler state encoding.
package gpu_pkg;

   localparam int CMD_W   = 29;
   localparam int PARAM_W = 25;
   localparam int OPC_W   = CMD_W - PARAM_W;

   typedef logic [OPC_W-1:0] opcode_t;

   localparam opcode_t OP_CLEAR     = 4'h0;
   localparam opcode_t OP_SET_XY1   = 4'h1;
   localparam opcode_t OP_SET_XY2   = 4'h2;
   localparam opcode_t OP_SET_RAD   = 4'h3;
   localparam opcode_t OP_DRAW_LINE = 4'h4;
   localparam opcode_t OP_NOP       = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      LOCKED,
      WAIT_DONE
   } sched_state_t;

   // Setup opcodes open or extend a draw sequence and therefore hold the lock.
   function automatic logic is_setup_op(input opcode_t op);
      return (op == OP_SET_XY1) || (op == OP_SET_XY2) || (op == OP_SET_RAD);
   endfunction

   // Anything above draw_line is unknown to the decoder and is swallowed here.
   function automatic logic is_issue_op(input opcode_t op);
      return op <= OP_DRAW_LINE;
   endfunction

endpackage

// File: rtl/gpu_cmd_scheduler_if.sv
// Requester, renderer and decoder-side signals of the command scheduler.
// The scheduler takes the slave view; requesters and the decoder the master view.
interface gpu_cmd_scheduler_if;
   import gpu_pkg::*;

   logic                req0_valid_i;
   logic [CMD_W-1:0]    req0_cmd_i;
   logic                req0_ready_o;
   logic                req1_valid_i;
   logic [CMD_W-1:0]    req1_cmd_i;
   logic                req1_ready_o;
   logic                finished_i;
   logic [OPC_W-1:0]    opcode_o;
   logic [PARAM_W-1:0]  parameters_o;
   logic                busy_o;
   logic                owner_o;
   logic                timeout_o;

   modport master (
      output req0_valid_i, req0_cmd_i, req1_valid_i, req1_cmd_i, finished_i,
      input  req0_ready_o, req1_ready_o, opcode_o, parameters_o,
             busy_o, owner_o, timeout_o
   );

   modport slave (
      input  req0_valid_i, req0_cmd_i, req1_valid_i, req1_cmd_i, finished_i,
      output req0_ready_o, req1_ready_o, opcode_o, parameters_o,
             busy_o, owner_o, timeout_o
   );

endinterface

// File: rtl/gpu_rr_arbiter.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester named by rr_prio.
module gpu_rr_arbiter (
   input  logic [1:0] valid,
   input  logic       rr_prio,
   output logic [1:0] grant
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      grant = valid;
      if (&valid) begin
         grant = rr_prio ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Shares the gpu_decoder command port between two requesters, locking it to
// one requester for a whole draw sequence and waiting for the renderer after draws.
module gpu_cmd_scheduler
   import gpu_pkg::*;
#(
   parameter int LOCK_TIMEOUT = 1024,
   parameter int CNT_W        = $clog2(LOCK_TIMEOUT + 1)
) (
   input logic              clk,
   input logic              rst,
   gpu_cmd_scheduler_if.slave bus
);

   localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(LOCK_TIMEOUT - 1);

   sched_state_t        state;
   logic                owner;
   logic                rr_prio;
   logic [CNT_W-1:0]    idle_cnt;
   logic [OPC_W-1:0]    opcode_q;
   logic [PARAM_W-1:0]  param_q;
   logic                timeout_q;

   logic [1:0]          valid;
   logic [1:0]          grant;
   logic [1:0]          ready;
   logic                accept;
   logic                acc_sel;
   logic [CMD_W-1:0]    acc_cmd;
   opcode_t             acc_op;
   logic [PARAM_W-1:0]  acc_par;

   assign valid = {bus.req1_valid_i, bus.req0_valid_i};

   gpu_rr_arbiter u_arb (
      .valid   (valid),
      .rr_prio (rr_prio),
      .grant   (grant)
   );

   // Ready never looks at the command itself, so requesters cannot form a loop.
   always_comb begin
      ready = '0;
      case (state)
         IDLE:    ready = grant;
         LOCKED:  ready[owner] = valid[owner];
         default: ready = '0;
      endcase
   end

   assign accept  = |(valid & ready);
   assign acc_sel = ready[1];
   assign acc_cmd = acc_sel ? bus.req1_cmd_i : bus.req0_cmd_i;
   assign acc_op  = acc_cmd[CMD_W-1:PARAM_W];
   assign acc_par = acc_cmd[PARAM_W-1:0];

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state     <= IDLE;
         owner     <= 1'b0;
         rr_prio   <= 1'b0;
         idle_cnt  <= '0;
         opcode_q  <= OP_NOP;
         param_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         // Default is NOP rather than clear: opcode 0 would wipe the decoder.
         opcode_q  <= OP_NOP;
         param_q   <= '0;
         timeout_q <= 1'b0;
         if (accept && is_issue_op(acc_op)) begin
            opcode_q <= acc_op;
            param_q  <= acc_par;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_setup_op(acc_op)) begin
                     state    <= LOCKED;
                     owner    <= acc_sel;
                     idle_cnt <= '0;
                  end else if (acc_op == OP_DRAW_LINE) begin
                     state <= WAIT_DONE;
                     owner <= acc_sel;
                  end
               end
            end

            LOCKED: begin
               // An owner accept on the expiry cycle takes precedence over the timeout.
               if (accept) begin
                  idle_cnt <= '0;
                  if (acc_op == OP_DRAW_LINE) begin
                     state <= WAIT_DONE;
                  end else if (acc_op == OP_CLEAR) begin
                     state   <= IDLE;
                     rr_prio <= ~owner;
                  end
               end else if (idle_cnt == IDLE_LIMIT) begin
                  state     <= IDLE;
                  rr_prio   <= ~owner;
                  timeout_q <= 1'b1;
                  idle_cnt  <= '0;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end

            WAIT_DONE: begin
               if (bus.finished_i) begin
                  state   <= IDLE;
                  rr_prio <= ~owner;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req0_ready_o = ready[0];
   assign bus.req1_ready_o = ready[1];
   assign bus.opcode_o     = opcode_q;
   assign bus.parameters_o = param_q;
   assign bus.busy_o       = (state != IDLE);
   assign bus.owner_o      = owner;
   assign bus.timeout_o    = timeout_q;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Directed and randomized stimulus for gpu_cmd_scheduler, compared every cycle
// against a transaction-level model of who holds the decoder port.
module tb_gpu_cmd_scheduler;

   localparam int LT = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gpu_cmd_scheduler_if bus ();

   gpu_cmd_scheduler #(.LOCK_TIMEOUT(LT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model of the port-sharing rules.
   bit          m_locked, m_drawing;
   int          m_holder, m_turn, m_idle;
   logic [3:0]  e_op;
   logic [24:0] e_par;
   bit          e_to;
   bit          last_acc0, last_acc1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [28:0] mk(input logic [3:0] op, input logic [24:0] par);
      return {op, par};
   endfunction

   function automatic logic [28:0] rand_cmd();
      int s;
      logic [3:0] op;
      s = $urandom_range(0, 9);
      if (s <= 4)      op = 4'(s);
      else if (s <= 8) op = 4'(s - 4);
      else             op = 4'($urandom_range(5, 15));
      return {op, 25'($urandom)};
   endfunction

   task automatic model_ready(input bit v0, input bit v1, output bit r0, output bit r1);
      r0 = 1'b0;
      r1 = 1'b0;
      if (m_drawing) begin
         r0 = 1'b0;
      end else if (m_locked) begin
         if (m_holder == 0) r0 = v0;
         else               r1 = v1;
      end else if (v0 && v1) begin
         r0 = (m_turn == 0);
         r1 = (m_turn == 1);
      end else begin
         r0 = v0;
         r1 = v1;
      end
   endtask

   task automatic model_step(input bit r, input bit acc, input int who,
                             input logic [28:0] cmd, input bit fin);
      int op;
      op    = int'(cmd[28:25]);
      e_op  = 4'hF;
      e_par = '0;
      e_to  = 1'b0;
      if (r) begin
         m_locked = 0; m_drawing = 0; m_holder = 0; m_turn = 0; m_idle = 0;
         return;
      end
      if (acc && op <= 4) begin
         e_op  = cmd[28:25];
         e_par = cmd[24:0];
      end
      if (m_drawing) begin
         if (fin) begin
            m_drawing = 0;
            m_turn    = 1 - m_holder;
         end
      end else if (acc) begin
         m_idle = 0;
         if (op == 4) begin
            m_drawing = 1; m_locked = 0; m_holder = who;
         end else if (op >= 1 && op <= 3) begin
            m_locked = 1; m_holder = who;
         end else if (op == 0 && m_locked) begin
            m_locked = 0; m_turn = 1 - m_holder;
         end
      end else if (m_locked) begin
         m_idle++;
         if (m_idle == LT) begin
            m_locked = 0; m_turn = 1 - m_holder; e_to = 1; m_idle = 0;
         end
      end
   endtask

   // One clock: drive inputs, check ready before the edge, check registered outputs after it.
   task automatic cycle(input bit r, input bit v0, input logic [28:0] c0,
                        input bit v1, input logic [28:0] c1, input bit fin);
      bit er0, er1, acc;
      int who;
      rst              = r;
      bus.req0_valid_i = v0;
      bus.req0_cmd_i   = c0;
      bus.req1_valid_i = v1;
      bus.req1_cmd_i   = c1;
      bus.finished_i   = fin;
      model_ready(v0, v1, er0, er1);
      @(negedge clk);
      if (!r) begin
         check("req0_ready", 64'(bus.req0_ready_o), 64'(er0));
         check("req1_ready", 64'(bus.req1_ready_o), 64'(er1));
      end
      acc       = !r && ((v0 && er0) || (v1 && er1));
      who       = (v1 && er1) ? 1 : 0;
      last_acc0 = acc && who == 0;
      last_acc1 = acc && who == 1;
      model_step(r, acc, who, (who == 1) ? c1 : c0, fin);
      @(posedge clk);
      #1;
      cyc++;
      check("opcode", 64'(bus.opcode_o), 64'(e_op));
      check("parameters", 64'(bus.parameters_o), 64'(e_par));
      check("busy", 64'(bus.busy_o), 64'(m_locked || m_drawing));
      check("timeout", 64'(bus.timeout_o), 64'(e_to));
      if (m_locked || m_drawing) check("owner", 64'(bus.owner_o), 64'(m_holder));
   endtask

   task automatic upd_req(inout bit v, inout logic [28:0] c, input bit acc, input int pct);
      if (!v || acc) begin
         v = ($urandom_range(0, 99) < pct);
         c = rand_cmd();
      end else if ($urandom_range(0, 9) == 0) begin
         v = 1'b0;
      end
   endtask

   initial begin
      int          to_at;
      bit          p0v, p1v;
      logic [28:0] p0c, p1c;
      int          pct;
      logic [28:0] z;
      z = '0;
      p0v = 0; p1v = 0; p0c = '0; p1c = '0; pct = 50;

      // Reset, then req0 runs a sequence; finished 5 cycles after the draw issue.
      cycle(1, 0, z, 0, z, 0);
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 1, mk(4'h1, 25'h00A05), 0, z, 0);
      cycle(0, 1, mk(4'h2, 25'h1E014), 0, z, 0);
      cycle(0, 1, mk(4'h4, 25'hFF0000), 0, z, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, z, 0, z, 0);
      cycle(0, 0, z, 0, z, 1);
      cycle(0, 1, mk(4'h0, 25'h0), 1, mk(4'h0, 25'h1), 0);

      // Both valid after reset: req0 first, req1 waits through the whole sequence.
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 1, mk(4'h1, 25'h11), 1, mk(4'h3, 25'h33), 0);
      cycle(0, 1, mk(4'h2, 25'h22), 1, mk(4'h3, 25'h33), 0);
      cycle(0, 1, mk(4'h4, 25'h44), 1, mk(4'h3, 25'h33), 0);
      cycle(0, 0, z, 1, mk(4'h3, 25'h33), 0);
      cycle(0, 0, z, 1, mk(4'h3, 25'h33), 1);
      cycle(0, 1, mk(4'h1, 25'h5), 1, mk(4'h3, 25'h33), 0);

      // req1 locks then goes silent: revoked after exactly LT idle cycles; req0 next.
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 0, z, 1, mk(4'h1, 25'h0ABCD), 0);
      to_at = 0;
      for (int k = 1; k <= LT; k++) begin
         cycle(0, 1, mk(4'h0, 25'h123), 0, z, 0);
         if (bus.timeout_o === 1'b1 && to_at == 0) to_at = k;
      end
      check("timeout_cycle", 64'(to_at), 64'(LT));
      cycle(0, 1, mk(4'h0, 25'h123), 0, z, 0);

      // Owner command lands exactly on the expiry cycle.
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 1, mk(4'h1, 25'h7), 0, z, 0);
      for (int k = 1; k < LT; k++) cycle(0, 0, z, 0, z, 0);
      cycle(0, 1, mk(4'h2, 25'h1FFFFFF), 0, z, 0);
      cycle(0, 0, z, 0, z, 0);

      // Idle cycles and a dropped unknown opcode keep the decoder at NOP/0.
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 0, z, 0, z, 1);
      cycle(0, 0, z, 1, mk(4'h7, 25'h1555555), 0);
      cycle(0, 1, mk(4'hF, 25'h0AAAAAA), 0, z, 0);
      cycle(0, 0, z, 0, z, 0);

      // Reset while waiting for the renderer.
      cycle(0, 0, z, 1, mk(4'h4, 25'h99), 0);
      cycle(0, 0, z, 0, z, 0);
      cycle(1, 0, z, 0, z, 0);
      cycle(0, 1, mk(4'h1, 25'h1), 1, mk(4'h1, 25'h2), 0);

      // Randomized traffic with alternating load levels.
      cycle(1, 0, z, 0, z, 0);
      last_acc0 = 0; last_acc1 = 0;
      for (int i = 0; i < 1500; i++) begin
         if (i % 64 == 0) pct = ($urandom_range(0, 1) == 1) ? 80 : 15;
         upd_req(p0v, p0c, last_acc0, pct);
         upd_req(p1v, p1c, last_acc1, pct);
         cycle($urandom_range(0, 299) == 0, p0v, p0c, p1v, p1c, $urandom_range(0, 3) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
